// File: rtl/execute_stage_if.sv
// Decode-to-execute input bundle and execute-to-memory register outputs of the execute stage.
interface execute_stage_if;
  logic [31:0] pc;
  logic [31:0] src1;
  logic [31:0] src2;
  logic [31:0] imm;
  logic [31:0] store_data;
  logic [3:0]  alu_op;
  logic        is_muldiv;
  logic [2:0]  funct3;
  logic        is_branch;
  logic        is_jump;
  logic        is_jalr;
  logic        w_enable;
  logic        is_store;
  logic        is_load;
  logic        is_load_unsigned;
  logic [4:0]  rd_addr;
  logic [1:0]  mem_access_width;
  logic        flush;

  logic        ex_stall;
  logic [31:0] EM_pc;
  logic [31:0] EM_alu_result;
  logic [31:0] EM_w_data;
  logic [31:0] EM_irreg_pc;
  logic        EM_w_enable;
  logic        EM_is_store;
  logic        EM_is_load;
  logic        EM_is_load_unsigned;
  logic [4:0]  EM_rd_addr;
  logic [1:0]  EM_mem_access_width;
  logic        EM_irreg_valid;

  modport master (
    output pc, src1, src2, imm, store_data, alu_op, is_muldiv, funct3,
           is_branch, is_jump, is_jalr, w_enable, is_store, is_load,
           is_load_unsigned, rd_addr, mem_access_width, flush,
    input  ex_stall, EM_pc, EM_alu_result, EM_w_data, EM_irreg_pc,
           EM_w_enable, EM_is_store, EM_is_load, EM_is_load_unsigned,
           EM_rd_addr, EM_mem_access_width, EM_irreg_valid
  );

  modport slave (
    input  pc, src1, src2, imm, store_data, alu_op, is_muldiv, funct3,
           is_branch, is_jump, is_jalr, w_enable, is_store, is_load,
           is_load_unsigned, rd_addr, mem_access_width, flush,
    output ex_stall, EM_pc, EM_alu_result, EM_w_data, EM_irreg_pc,
           EM_w_enable, EM_is_store, EM_is_load, EM_is_load_unsigned,
           EM_rd_addr, EM_mem_access_width, EM_irreg_valid
  );
endinterface

// File: rtl/execute_stage.sv
// RV32IM execute stage: ALU, branch/jump resolution, single-cycle multiply and
// a multi-cycle restoring divider that stalls upstream, feeding the EX/MEM register.
module execute_stage #(
  parameter int DIV_CYCLES = 32
) (
  input  logic           clk,
  input  logic           rstd,
  execute_stage_if.slave bus
);

  typedef enum logic [1:0] {IDLE, DIV, DONE} div_state_t;

  localparam int CNT_W = (DIV_CYCLES > 1) ? $clog2(DIV_CYCLES) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DIV_CYCLES - 1);

  function automatic logic [31:0] alu_fn(input logic [3:0] op,
                                         input logic [31:0] a,
                                         input logic [31:0] b);
    logic signed [31:0] sa;
    logic signed [31:0] sb;
    logic        [4:0]  sh;
    sa = $signed(a);
    sb = $signed(b);
    sh = b[4:0];
    case (op)
      4'd0:    return a + b;
      4'd1:    return a - b;
      4'd2:    return a << sh;
      4'd3:    return {31'd0, sa < sb};
      4'd4:    return {31'd0, a < b};
      4'd5:    return a ^ b;
      4'd6:    return a >> sh;
      4'd7:    return $unsigned(sa >>> sh);
      4'd8:    return a | b;
      4'd9:    return a & b;
      default: return 32'd0;
    endcase
  endfunction

  // f: 0 MUL (low word), 1 MULH (s*s), 2 MULHSU (s*u), 3 MULHU (u*u)
  function automatic logic [31:0] mul_fn(input logic [1:0] f,
                                         input logic [31:0] a,
                                         input logic [31:0] b);
    logic signed [63:0] ea;
    logic signed [63:0] eb;
    logic signed [63:0] prod;
    ea   = (f == 2'd1 || f == 2'd2) ? {{32{a[31]}}, a} : {32'd0, a};
    eb   = (f == 2'd1) ? {{32{b[31]}}, b} : {32'd0, b};
    prod = ea * eb;
    return (f == 2'd0) ? prod[31:0] : prod[63:32];
  endfunction

  function automatic logic br_taken(input logic [2:0] f,
                                    input logic [31:0] a,
                                    input logic [31:0] b);
    logic signed [31:0] sa;
    logic signed [31:0] sb;
    sa = $signed(a);
    sb = $signed(b);
    case (f)
      3'd0:    return a == b;
      3'd1:    return a != b;
      3'd4:    return sa < sb;
      3'd5:    return sa >= sb;
      3'd6:    return a < b;
      3'd7:    return a >= b;
      default: return 1'b0;
    endcase
  endfunction

  function automatic logic [31:0] mag(input logic sgn, input logic [31:0] v);
    return (sgn && v[31]) ? (~v + 32'd1) : v;
  endfunction

  function automatic logic [31:0] sign_fix(input logic neg, input logic [31:0] v);
    return neg ? (~v + 32'd1) : v;
  endfunction

  div_state_t       state;
  logic [CNT_W-1:0] cnt;

  logic [31:0] quo_p1;
  logic [31:0] rem_p1;
  logic [31:0] dvs_p1;
  logic        neg_q_p1;
  logic        neg_r_p1;
  logic        is_rem_p1;

  logic        div_op;
  logic        div_signed;
  logic        div_zero;
  logic        div_ovf;
  logic        div_special;
  logic        div_start;
  logic [31:0] div_special_result;
  logic [31:0] div_result;
  logic [32:0] rem_sh;
  logic [32:0] rem_diff;
  logic        stall;

  logic [31:0] ex_result;
  logic [31:0] target;
  logic        redirect;

  assign div_op      = bus.is_muldiv && bus.funct3[2];
  assign div_signed  = !bus.funct3[0];
  assign div_zero    = (bus.src2 == 32'd0);
  assign div_ovf     = div_signed && (bus.src1 == 32'h8000_0000) && (bus.src2 == 32'hFFFF_FFFF);
  assign div_special = div_zero || div_ovf;
  assign div_start   = (state == IDLE) && div_op && !div_special && !bus.flush;

  // Special cases resolve in one cycle; funct3[1] selects remainder.
  always_comb begin
    div_special_result = 32'd0;
    if (div_zero)
      div_special_result = bus.funct3[1] ? bus.src1 : 32'hFFFF_FFFF;
    else if (div_ovf)
      div_special_result = bus.funct3[1] ? 32'd0 : 32'h8000_0000;
  end

  assign stall       = rstd && !bus.flush && (div_start || state == DIV);
  assign bus.ex_stall = stall;

  assign rem_sh     = {rem_p1, quo_p1[31]};
  assign rem_diff   = rem_sh - {1'b0, dvs_p1};
  assign div_result = is_rem_p1 ? sign_fix(neg_r_p1, rem_p1) : sign_fix(neg_q_p1, quo_p1);

  always_ff @(posedge clk or negedge rstd) begin
    if (!rstd) begin
      state <= IDLE;
      cnt   <= '0;
    end else if (bus.flush) begin
      state <= IDLE;
      cnt   <= '0;
    end else begin
      case (state)
        IDLE: if (div_start) begin
          state <= DIV;
          cnt   <= '0;
        end
        DIV: if (cnt == CNT_LAST) state <= DONE;
             else                 cnt   <= cnt + CNT_W'(1);
        DONE:    state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

  // Divider datapath: operands latched as magnitudes, one restoring step per DIV cycle
  always_ff @(posedge clk) begin
    if (div_start) begin
      quo_p1    <= mag(div_signed, bus.src1);
      rem_p1    <= 32'd0;
      dvs_p1    <= mag(div_signed, bus.src2);
      neg_q_p1  <= div_signed && (bus.src1[31] ^ bus.src2[31]);
      neg_r_p1  <= div_signed && bus.src1[31];
      is_rem_p1 <= bus.funct3[1];
    end else if (state == DIV) begin
      quo_p1 <= {quo_p1[30:0], !rem_diff[32]};
      rem_p1 <= rem_diff[32] ? rem_sh[31:0] : rem_diff[31:0];
    end
  end

  always_comb begin
    redirect  = 1'b0;
    target    = bus.pc + bus.imm;
    ex_result = alu_fn(bus.alu_op, bus.src1, bus.src2);
    if (bus.is_jump) begin
      ex_result = bus.pc + 32'd4;
      redirect  = 1'b1;
      if (bus.is_jalr) target = bus.src1 + bus.imm;
    end else begin
      if (bus.is_muldiv) begin
        if (!bus.funct3[2])      ex_result = mul_fn(bus.funct3[1:0], bus.src1, bus.src2);
        else if (state == DONE)  ex_result = div_result;
        else                     ex_result = div_special_result;
      end
      redirect = bus.is_branch && br_taken(bus.funct3, bus.src1, bus.src2);
    end
  end

  logic [31:0] pc_p1;
  logic [31:0] alu_p1;
  logic [31:0] wdata_p1;
  logic [31:0] irreg_pc_p1;
  logic        we_p1;
  logic        st_p1;
  logic        ld_p1;
  logic        ldu_p1;
  logic [4:0]  rd_p1;
  logic [1:0]  maw_p1;
  logic        irreg_vld_p1;

  // EX/MEM boundary: stalled or flushed cycles hand a zeroed bubble downstream
  always_ff @(posedge clk or negedge rstd) begin
    if (!rstd) begin
      pc_p1        <= '0;
      alu_p1       <= '0;
      wdata_p1     <= '0;
      irreg_pc_p1  <= '0;
      we_p1        <= 1'b0;
      st_p1        <= 1'b0;
      ld_p1        <= 1'b0;
      ldu_p1       <= 1'b0;
      rd_p1        <= '0;
      maw_p1       <= '0;
      irreg_vld_p1 <= 1'b0;
    end else if (bus.flush || stall) begin
      pc_p1        <= '0;
      alu_p1       <= '0;
      wdata_p1     <= '0;
      irreg_pc_p1  <= '0;
      we_p1        <= 1'b0;
      st_p1        <= 1'b0;
      ld_p1        <= 1'b0;
      ldu_p1       <= 1'b0;
      rd_p1        <= '0;
      maw_p1       <= '0;
      irreg_vld_p1 <= 1'b0;
    end else begin
      pc_p1        <= bus.pc;
      alu_p1       <= ex_result;
      wdata_p1     <= bus.store_data;
      irreg_pc_p1  <= redirect ? target : 32'd0;
      we_p1        <= bus.w_enable;
      st_p1        <= bus.is_store;
      ld_p1        <= bus.is_load;
      ldu_p1       <= bus.is_load_unsigned;
      rd_p1        <= bus.rd_addr;
      maw_p1       <= bus.mem_access_width;
      irreg_vld_p1 <= redirect;
    end
  end

  assign bus.EM_pc               = pc_p1;
  assign bus.EM_alu_result       = alu_p1;
  assign bus.EM_w_data           = wdata_p1;
  assign bus.EM_irreg_pc         = irreg_pc_p1;
  assign bus.EM_w_enable         = we_p1;
  assign bus.EM_is_store         = st_p1;
  assign bus.EM_is_load          = ld_p1;
  assign bus.EM_is_load_unsigned = ldu_p1;
  assign bus.EM_rd_addr          = rd_p1;
  assign bus.EM_mem_access_width = maw_p1;
  assign bus.EM_irreg_valid      = irreg_vld_p1;

endmodule

// File: tb/tb_execute_stage.sv
// Directed bench for execute_stage: an arithmetic reference model checked every
// cycle, plus hand-computed literal expectations for the key vectors.
module tb_execute_stage;

  logic clk = 1'b0;
  logic rstd;
  always #5 clk = ~clk;

  execute_stage_if bus();

  execute_stage #(.DIV_CYCLES(32)) dut (
    .clk  (clk),
    .rstd (rstd),
    .bus  (bus)
  );

  int n_cmp = 0;
  int n_bad = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] alu;
    logic [31:0] wdata;
    logic [31:0] ipc;
    logic        we;
    logic        st;
    logic        ld;
    logic        ldu;
    logic        iv;
    logic [4:0]  rd;
    logic [1:0]  maw;
  } em_t;

  em_t exp_em = '0;
  int  dk = -1;  // edges since a long divide started; -1 when none in flight

  function automatic logic [31:0] ref_alu(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b);
    int ia;
    int ib;
    ia = a;
    ib = b;
    case (op)
      4'd0: return a + b;
      4'd1: return a - b;
      4'd2: return a << b[4:0];
      4'd3: return (ia < ib) ? 32'd1 : 32'd0;
      4'd4: return (a < b) ? 32'd1 : 32'd0;
      4'd5: return a ^ b;
      4'd6: return a >> b[4:0];
      4'd7: return ia >>> b[4:0];
      4'd8: return a | b;
      4'd9: return a & b;
      default: return 32'd0;
    endcase
  endfunction

  function automatic logic [31:0] ref_m(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b);
    longint sa, sb, ua, ub, p;
    int ia, ib;
    logic ovf;
    sa = longint'(int'(a));
    sb = longint'(int'(b));
    ua = longint'({32'd0, a});
    ub = longint'({32'd0, b});
    ia = a;
    ib = b;
    ovf = (a == 32'h8000_0000) && (b == 32'hFFFF_FFFF);
    case (f)
      3'd0: begin p = ua * ub; return p[31:0]; end
      3'd1: begin p = sa * sb; return p[63:32]; end
      3'd2: begin p = sa * ub; return p[63:32]; end
      3'd3: begin p = ua * ub; return p[63:32]; end
      3'd4: if (b == 0) return 32'hFFFF_FFFF; else if (ovf) return a; else return ia / ib;
      3'd5: if (b == 0) return 32'hFFFF_FFFF; else return a / b;
      3'd6: if (b == 0) return a; else if (ovf) return 32'd0; else return ia % ib;
      default: if (b == 0) return a; else return a % b;
    endcase
  endfunction

  function automatic logic ref_br(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b);
    int ia;
    int ib;
    ia = a;
    ib = b;
    case (f)
      3'd0: return a == b;
      3'd1: return a != b;
      3'd4: return ia < ib;
      3'd5: return ia >= ib;
      3'd6: return a < b;
      3'd7: return a >= b;
      default: return 1'b0;
    endcase
  endfunction

  function automatic logic div_long();
    return bus.is_muldiv && bus.funct3[2] && (bus.src2 != 0) &&
           !(!bus.funct3[0] && bus.src1 == 32'h8000_0000 && bus.src2 == 32'hFFFF_FFFF);
  endfunction

  function automatic em_t ref_instr();
    em_t e;
    logic taken;
    logic [31:0] tgt;
    e.pc = bus.pc;
    e.wdata = bus.store_data;
    e.we = bus.w_enable;
    e.st = bus.is_store;
    e.ld = bus.is_load;
    e.ldu = bus.is_load_unsigned;
    e.rd = bus.rd_addr;
    e.maw = bus.mem_access_width;
    if (bus.is_jump) begin
      e.alu = bus.pc + 4;
      taken = 1'b1;
      tgt = bus.is_jalr ? bus.src1 + bus.imm : bus.pc + bus.imm;
    end else begin
      e.alu = bus.is_muldiv ? ref_m(bus.funct3, bus.src1, bus.src2) : ref_alu(bus.alu_op, bus.src1, bus.src2);
      taken = bus.is_branch && ref_br(bus.funct3, bus.src1, bus.src2);
      tgt = bus.pc + bus.imm;
    end
    e.iv = taken;
    e.ipc = taken ? tgt : 32'd0;
    return e;
  endfunction

  function automatic logic exp_stall();
    return rstd && !bus.flush && ((dk == -1 && div_long()) || (dk >= 1 && dk <= 32));
  endfunction

  always @(posedge clk or negedge rstd) begin
    if (!rstd) begin
      exp_em <= '0;
      dk <= -1;
    end else if (bus.flush) begin
      exp_em <= '0;
      dk <= -1;
    end else if (dk >= 1 && dk <= 32) begin
      exp_em <= '0;
      dk <= dk + 1;
    end else if (dk == 33) begin
      exp_em <= ref_instr();
      dk <= -1;
    end else if (div_long()) begin
      exp_em <= '0;
      dk <= 1;
    end else begin
      exp_em <= ref_instr();
    end
  end

  always @(negedge clk) begin
    check("ex_stall", {31'd0, bus.ex_stall}, {31'd0, exp_stall()});
    check("EM_pc", bus.EM_pc, exp_em.pc);
    check("EM_alu_result", bus.EM_alu_result, exp_em.alu);
    check("EM_w_data", bus.EM_w_data, exp_em.wdata);
    check("EM_irreg_pc", bus.EM_irreg_pc, exp_em.ipc);
    check("EM_ctrl", {27'd0, bus.EM_w_enable, bus.EM_is_store, bus.EM_is_load,
                      bus.EM_is_load_unsigned, bus.EM_irreg_valid},
                     {27'd0, exp_em.we, exp_em.st, exp_em.ld, exp_em.ldu, exp_em.iv});
    check("EM_rd_addr", {27'd0, bus.EM_rd_addr}, {27'd0, exp_em.rd});
    check("EM_maw", {30'd0, bus.EM_mem_access_width}, {30'd0, exp_em.maw});
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic clr();
    bus.pc = 32'h0; bus.src1 = 32'h0; bus.src2 = 32'h0; bus.imm = 32'h0;
    bus.store_data = 32'h0; bus.alu_op = 4'd0; bus.is_muldiv = 1'b0; bus.funct3 = 3'd0;
    bus.is_branch = 1'b0; bus.is_jump = 1'b0; bus.is_jalr = 1'b0; bus.w_enable = 1'b0;
    bus.is_store = 1'b0; bus.is_load = 1'b0; bus.is_load_unsigned = 1'b0;
    bus.rd_addr = 5'd0; bus.mem_access_width = 2'd0; bus.flush = 1'b0;
  endtask

  task automatic alu_i(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b, input logic [4:0] rd);
    clr();
    bus.pc = 32'h40; bus.alu_op = op; bus.src1 = a; bus.src2 = b;
    bus.w_enable = 1'b1; bus.rd_addr = rd; bus.store_data = b ^ 32'h5A5A_0000;
    bus.mem_access_width = 2'd2;
  endtask

  task automatic m_i(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b);
    clr();
    bus.pc = 32'h80; bus.is_muldiv = 1'b1; bus.funct3 = f; bus.src1 = a; bus.src2 = b;
    bus.w_enable = 1'b1; bus.rd_addr = 5'd9;
  endtask

  task automatic br_i(input logic [2:0] f, input logic [31:0] pc, input logic [31:0] imm,
                      input logic [31:0] a, input logic [31:0] b);
    clr();
    bus.pc = pc; bus.imm = imm; bus.is_branch = 1'b1; bus.funct3 = f; bus.src1 = a; bus.src2 = b;
  endtask

  // Runs a long divide to completion; inputs are held until the result edge.
  task automatic run_div(input string name, input logic [31:0] want);
    int n;
    n = 0;
    #1;
    while (bus.ex_stall && n < 100) begin
      @(posedge clk);
      #2;
      n++;
    end
    check({name, "_stall_cycles"}, n, 33);
    step();
    check(name, bus.EM_alu_result, want);
    check({name, "_we"}, {31'd0, bus.EM_w_enable}, 32'd1);
  endtask

  logic [31:0] alu_a [4] = '{32'h8000_0F0F, 32'h0000_0007, 32'hFFFF_FFFF, 32'h1234_5678};
  logic [31:0] alu_b [4] = '{32'h0000_0024, 32'hFFFF_FFF8, 32'h0000_0001, 32'h0000_001F};

  initial begin
    rstd = 1'b0;
    clr();
    repeat (2) @(posedge clk);
    #1;
    check("rst_alu", bus.EM_alu_result, 32'd0);
    check("rst_we", {31'd0, bus.EM_w_enable}, 32'd0);
    check("rst_stall", {31'd0, bus.ex_stall}, 32'd0);
    rstd = 1'b1;

    alu_i(4'd0, 32'd5, 32'hFFFF_FFFD, 5'd3);
    step();
    check("add_res", bus.EM_alu_result, 32'd2);
    check("add_rd", {27'd0, bus.EM_rd_addr}, 32'd3);
    check("add_we", {31'd0, bus.EM_w_enable}, 32'd1);

    for (int v = 0; v < 4; v++)
      for (int op = 0; op < 16; op++) begin
        alu_i(op[3:0], alu_a[v], alu_b[v], 5'd7);
        step();
      end
    alu_i(4'd7, 32'h8000_0000, 32'd4, 5'd1);
    step();
    check("sra", bus.EM_alu_result, 32'hF800_0000);
    alu_i(4'd3, 32'hFFFF_FFFF, 32'd1, 5'd1);
    step();
    check("slt", bus.EM_alu_result, 32'd1);
    alu_i(4'd4, 32'hFFFF_FFFF, 32'd1, 5'd1);
    step();
    check("sltu", bus.EM_alu_result, 32'd0);

    m_i(3'd1, 32'h8000_0000, 32'd2); step(); check("mulh", bus.EM_alu_result, 32'hFFFF_FFFF);
    m_i(3'd3, 32'h8000_0000, 32'd2); step(); check("mulhu", bus.EM_alu_result, 32'd1);
    m_i(3'd0, 32'hFFFF_FFFF, 32'hFFFF_FFFF); step(); check("mul", bus.EM_alu_result, 32'd1);
    m_i(3'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFF); step(); check("mulhsu", bus.EM_alu_result, 32'hFFFF_FFFF);

    m_i(3'd4, 32'hFFFF_FFF9, 32'd2);
    run_div("div", 32'hFFFF_FFFD);
    m_i(3'd6, 32'hFFFF_FFF9, 32'd2);
    run_div("rem", 32'hFFFF_FFFF);
    m_i(3'd5, 32'd1000, 32'd7);
    run_div("divu", 32'd142);
    m_i(3'd7, 32'h8000_0000, 32'hFFFF_FFFF);
    run_div("remu", 32'h8000_0000);

    m_i(3'd5, 32'd10, 32'd0);
    #1;
    check("divu0_stall", {31'd0, bus.ex_stall}, 32'd0);
    step();
    check("divu0", bus.EM_alu_result, 32'hFFFF_FFFF);
    m_i(3'd6, 32'h8000_0000, 32'hFFFF_FFFF);
    #1;
    check("removf_stall", {31'd0, bus.ex_stall}, 32'd0);
    step();
    check("removf", bus.EM_alu_result, 32'd0);
    m_i(3'd4, 32'h8000_0000, 32'hFFFF_FFFF); step();
    check("divovf", bus.EM_alu_result, 32'h8000_0000);

    br_i(3'd4, 32'h100, 32'h20, 32'hFFFF_FFFF, 32'd1); step();
    check("blt_v", {31'd0, bus.EM_irreg_valid}, 32'd1);
    check("blt_pc", bus.EM_irreg_pc, 32'h120);
    br_i(3'd7, 32'h100, 32'h20, 32'hFFFF_FFFF, 32'd1); step();
    check("bgeu_v", {31'd0, bus.EM_irreg_valid}, 32'd1);
    br_i(3'd6, 32'h100, 32'h20, 32'hFFFF_FFFF, 32'd1); step();
    check("bltu_v", {31'd0, bus.EM_irreg_valid}, 32'd0);
    check("bltu_pc", bus.EM_irreg_pc, 32'd0);
    for (int f = 0; f < 8; f++) begin
      br_i(f[2:0], 32'h300, 32'hFFFF_FFF0, 32'd5, 32'd5); step();
    end

    clr();
    bus.pc = 32'h200; bus.imm = 32'h40; bus.is_jump = 1'b1; bus.w_enable = 1'b1; bus.rd_addr = 5'd1;
    step();
    check("jal_link", bus.EM_alu_result, 32'h204);
    check("jal_tgt", bus.EM_irreg_pc, 32'h240);
    bus.is_jalr = 1'b1; bus.src1 = 32'h1000; bus.imm = 32'h8;
    step();
    check("jalr_tgt", bus.EM_irreg_pc, 32'h1008);

    m_i(3'd5, 32'd1000, 32'd7);
    repeat (9) @(posedge clk);
    #1;
    bus.flush = 1'b1;
    #1;
    check("flush_stall", {31'd0, bus.ex_stall}, 32'd0);
    step();
    check("flush_bubble", {31'd0, bus.EM_w_enable}, 32'd0);
    alu_i(4'd8, 32'hF0, 32'h0F, 5'd4);
    #1;
    check("post_flush_stall", {31'd0, bus.ex_stall}, 32'd0);
    step();
    check("post_flush_or", bus.EM_alu_result, 32'hFF);

    m_i(3'd4, 32'd50, 32'd3);
    bus.flush = 1'b1;
    step();
    check("flush_prio_we", {31'd0, bus.EM_w_enable}, 32'd0);

    alu_i(4'd0, 32'd100, 32'd23, 5'd6);
    step();
    #1;
    rstd = 1'b0;
    #1;
    check("async_rst_alu", bus.EM_alu_result, 32'd0);
    check("async_rst_rd", {27'd0, bus.EM_rd_addr}, 32'd0);
    @(posedge clk); #1;
    rstd = 1'b1;

    m_i(3'd4, 32'd77, 32'd5);
    repeat (5) step();
    #1;
    rstd = 1'b0;
    #1;
    check("rst_mid_stall", {31'd0, bus.ex_stall}, 32'd0);
    check("rst_mid_we", {31'd0, bus.EM_w_enable}, 32'd0);
    clr();
    @(posedge clk); #1;
    rstd = 1'b1;
    alu_i(4'd1, 32'd10, 32'd3, 5'd2);
    #1;
    check("post_rst_stall", {31'd0, bus.ex_stall}, 32'd0);
    step();
    check("post_rst_sub", bus.EM_alu_result, 32'd7);
    clr();
    repeat (2) step();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
